prot_trig_capture_ctrl: RTL and testbench

PROT_TRIG_CAPTURE_CTRL -- requirements
Module: prot_trig_capture_ctrl

---
 rtl/prot_trig_capture_ctrl_if.sv | 25 ++
 rtl/prot_trig_capture_ctrl.sv | 69 ++++++
 tb/tb_prot_trig_capture_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/prot_trig_capture_ctrl_if.sv
// prot_trig_capture_ctrl_if: control/status bundle between capture controller and its host.
// Host drives arm, clr_done, smpl_en, protTrig, force_trig and trig_pos.
// The controller returns armed, triggered, capture_done, wrt_en, waddr and trig_addr.
interface prot_trig_capture_ctrl_if #(parameter int ADDR_W = 9);
    logic              arm;
    logic              clr_done;
    logic              smpl_en;
    logic              protTrig;
    logic              force_trig;
    logic [ADDR_W-1:0] trig_pos;
    logic              armed;
    logic              triggered;
    logic              capture_done;
    logic              wrt_en;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] trig_addr;
    modport master (
        output arm, clr_done, smpl_en, protTrig, force_trig, trig_pos,
        input  armed, triggered, capture_done, wrt_en, waddr, trig_addr
    );
    modport slave (
        input  arm, clr_done, smpl_en, protTrig, force_trig, trig_pos,
        output armed, triggered, capture_done, wrt_en, waddr, trig_addr
    );
endinterface

// File: rtl/prot_trig_capture_ctrl.sv
// prot_trig_capture_ctrl: circular capture buffer controller with pre/post trigger windows.
// Ports: clk, rst_n (async, active-low), bus (slave side of prot_trig_capture_ctrl_if):
//   inputs arm, clr_done, smpl_en, protTrig, force_trig, trig_pos;
//   outputs armed, triggered, capture_done, wrt_en, waddr, trig_addr.
module prot_trig_capture_ctrl #(
    parameter int ADDR_W = 9
) (
    input logic                     clk,
    input logic                     rst_n,
    prot_trig_capture_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRE   = 3'd1;
    localparam logic [2:0] S_ARMED = 3'd2;
    localparam logic [2:0] S_POST  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [2:0]        state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_inc;
    logic [ADDR_W-1:0] waddr, trig_addr, waddr_inc;
    logic              trig_q, trig_evt, wrt, pre_hit, post_hit, counting;

    // trig_q resets high so a level already asserted at reset is not seen as an edge
    assign trig_evt  = (bus.protTrig | bus.force_trig) & ~trig_q;
    assign wrt       = bus.smpl_en & (state == S_PRE || state == S_ARMED || state == S_POST);
    assign waddr_inc = waddr + ADDR_W'(wrt);
    assign cnt_inc   = cnt + 1'b1;
    assign pre_hit   = wrt && cnt_inc == DEPTH - {1'b0, bus.trig_pos};
    assign post_hit  = wrt && cnt_inc == {1'b0, bus.trig_pos};
    // writes in ARMED belong to the pre-trigger window but are not counted
    assign counting  = wrt && (state == S_PRE || state == S_POST);

    always_comb begin
        state_nxt = state;
        case (state)
            S_PRE:   if (pre_hit) state_nxt = S_ARMED;
            S_ARMED: if (trig_evt) state_nxt = (bus.trig_pos == '0) ? S_DONE : S_POST;
            S_POST:  if (post_hit) state_nxt = S_DONE;
            S_DONE:  if (bus.clr_done) state_nxt = S_IDLE;
            default: ;
        endcase
        if (bus.arm) state_nxt = S_PRE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            waddr     <= '0;
            trig_addr <= '0;
            trig_q    <= 1'b1;
        end else begin
            trig_q <= bus.protTrig | bus.force_trig;
            state  <= state_nxt;
            waddr  <= bus.arm ? '0 : waddr_inc;
            cnt    <= (bus.arm || state_nxt != state) ? '0 : counting ? cnt_inc : cnt;
            // oldest sample is the slot after the final write
            if (!bus.arm && state_nxt == S_DONE && state != S_DONE) trig_addr <= waddr_inc;
        end
    end

    assign bus.armed        = state == S_ARMED;
    assign bus.triggered    = state == S_POST || state == S_DONE;
    assign bus.capture_done = state == S_DONE;
    assign bus.wrt_en       = wrt;
    assign bus.waddr        = waddr;
    assign bus.trig_addr    = trig_addr;
endmodule

// File: tb/tb_prot_trig_capture_ctrl.sv
// tb_prot_trig_capture_ctrl: directed self-checking bench for prot_trig_capture_ctrl (ADDR_W=4).
module tb_prot_trig_capture_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    prot_trig_capture_ctrl_if #(.ADDR_W(4)) bus ();
    prot_trig_capture_ctrl #(.ADDR_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_armed"}, 32'(bus.armed), 0);
        check({tag, "_trig"},  32'(bus.triggered), 0);
        check({tag, "_done"},  32'(bus.capture_done), 0);
        check({tag, "_wen"},   32'(bus.wrt_en), 0);
        check({tag, "_waddr"}, 32'(bus.waddr), 0);
    endtask

    // arm, then stream n writes checking armed stays low until the last one
    task automatic arm_and_fill(input string tag, input int n);
        bus.arm = 1'b1;
        step();
        bus.arm = 1'b0;
        bus.smpl_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1) check({tag, "_pre_armed"}, 32'(bus.armed), 0);
            step();
        end
        check({tag, "_armed"}, 32'(bus.armed), 1);
        bus.smpl_en = 1'b0;
    endtask

    initial begin
        bus.arm = 0; bus.clr_done = 0; bus.smpl_en = 1; bus.protTrig = 0;
        bus.force_trig = 0; bus.trig_pos = 4'd4;
        #12;
        check_idle_outputs("reset");
        check("reset_taddr", 32'(bus.trig_addr), 0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_wen", 32'(bus.wrt_en), 0);
        bus.smpl_en = 0;

        // basic capture, trig_pos=4
        arm_and_fill("t1", 12);
        check("t1_waddr_armed", 32'(bus.waddr), 12);
        step(2);
        check("t1_still_armed", 32'(bus.armed), 1);
        bus.protTrig = 1;
        check("t1_trig_edge_cycle", 32'(bus.triggered), 0);
        step();
        check("t1_triggered", 32'(bus.triggered), 1);
        check("t1_not_armed", 32'(bus.armed), 0);
        bus.protTrig = 0;
        bus.smpl_en = 1;
        step(3);
        check("t1_not_done", 32'(bus.capture_done), 0);
        step();
        check("t1_done", 32'(bus.capture_done), 1);
        check("t1_waddr", 32'(bus.waddr), 0);
        check("t1_taddr", 32'(bus.trig_addr), 0);
        check("t1_wen_done", 32'(bus.wrt_en), 0);
        bus.smpl_en = 0;
        bus.clr_done = 1;
        step();
        bus.clr_done = 0;
        check("clr_done", 32'(bus.capture_done), 0);
        check("clr_trig", 32'(bus.triggered), 0);
        bus.smpl_en = 1;
        #1;
        check("clr_idle_wen", 32'(bus.wrt_en), 0);
        bus.smpl_en = 0;

        // edges in PRETRIG ignored, held level is not an edge
        bus.trig_pos = 4'd8;
        bus.arm = 1;
        step();
        bus.arm = 0;
        bus.smpl_en = 1;
        for (int i = 0; i < 8; i++) begin
            bus.protTrig = (i != 1);
            step();
        end
        check("t2_armed", 32'(bus.armed), 1);
        bus.smpl_en = 0;
        step(3);
        check("t2_held_armed", 32'(bus.armed), 1);
        check("t2_held_notrig", 32'(bus.triggered), 0);
        bus.protTrig = 0;
        step();
        bus.protTrig = 1;
        step();
        check("t2_triggered", 32'(bus.triggered), 1);
        bus.protTrig = 0;
        bus.smpl_en = 1;
        step(7);
        check("t2_not_done", 32'(bus.capture_done), 0);
        step();
        bus.smpl_en = 0;
        check("t2_done", 32'(bus.capture_done), 1);
        check("t2_taddr", 32'(bus.trig_addr), 0);

        // arm beats clr_done in DONE
        bus.arm = 1; bus.clr_done = 1;
        step();
        bus.arm = 0; bus.clr_done = 0;
        check("combo_done", 32'(bus.capture_done), 0);
        check("combo_trig", 32'(bus.triggered), 0);
        bus.smpl_en = 1;
        #1;
        check("combo_pretrig_wen", 32'(bus.wrt_en), 1);
        bus.smpl_en = 0;

        // trig_pos=0: full pre window, force_trig goes straight to DONE
        bus.trig_pos = 4'd0;
        arm_and_fill("t3", 16);
        check("t3_waddr_armed", 32'(bus.waddr), 0);
        bus.smpl_en = 1;
        step(3);
        bus.force_trig = 1;
        step();
        check("t3_done", 32'(bus.capture_done), 1);
        check("t3_triggered", 32'(bus.triggered), 1);
        check("t3_waddr", 32'(bus.waddr), 4);
        check("t3_taddr", 32'(bus.trig_addr), 4);
        check("t3_wen_after", 32'(bus.wrt_en), 0);
        step();
        check("t3_waddr_hold", 32'(bus.waddr), 4);
        bus.force_trig = 0;
        bus.smpl_en = 0;

        // arm aborts POSTTRIG
        bus.trig_pos = 4'd4;
        arm_and_fill("t4", 12);
        bus.protTrig = 1;
        step();
        check("t4_triggered", 32'(bus.triggered), 1);
        bus.smpl_en = 1;
        step(2);
        check("t4_waddr_post", 32'(bus.waddr), 14);
        bus.arm = 1;
        step();
        bus.arm = 0;
        check("t4_abort_waddr", 32'(bus.waddr), 0);
        check("t4_abort_trig", 32'(bus.triggered), 0);
        check("t4_abort_done", 32'(bus.capture_done), 0);
        check("t4_abort_wen", 32'(bus.wrt_en), 1);
        bus.smpl_en = 0;

        // held level in ARMED, clr_done ignored, then reset
        arm_and_fill("t5", 12);
        check("t5_level_notrig", 32'(bus.triggered), 0);
        bus.clr_done = 1;
        step();
        bus.clr_done = 0;
        check("t5_clr_ignored", 32'(bus.armed), 1);
        rst_n = 0;
        #1;
        check_idle_outputs("t5_rst");
        check("t5_rst_taddr", 32'(bus.trig_addr), 0);
        step(2);
        rst_n = 1;
        step(2);
        check("t5_post_rst_armed", 32'(bus.armed), 0);
        check("t5_post_rst_trig", 32'(bus.triggered), 0);
        arm_and_fill("t6", 12);
        step(2);
        check("t6_level_notrig", 32'(bus.triggered), 0);
        bus.protTrig = 0;
        step();
        bus.protTrig = 1;
        step();
        check("t6_fresh_edge", 32'(bus.triggered), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
